// File: rtl/issue_queue_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : issue_queue_mp_pkg
// Description : Shared helpers for the multi-port issue queue. Provides the
//               width functions used to size the FU select field, the slot
//               index and the occupancy counter from the top-level parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package issue_queue_mp_pkg;

    // Width of an index into n items; never collapses to zero bits so a
    // single-FU configuration still has a legal select field.
    function automatic int iq_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold the value n itself (0..n).
    function automatic int iq_cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/issue_queue_mp_age_select.sv
`default_nettype none
// ============================================================================
// Module      : iq_age_select
// Description : Oldest-first arbiter. Given a request vector and the age
//               matrix (i_age[j][i] = 1 means entry j is older than entry i)
//               returns a one-hot grant for the oldest requester, or zero
//               when nothing requests.
// Ports       : i_req   - per-entry request
//               i_age   - ENTRIES x ENTRIES age matrix
//               o_grant - one-hot oldest requester
// Revision    : 1.0 - initial release
// ============================================================================
module iq_age_select #(
    parameter int ENTRIES = 8
) (
    input  logic [ENTRIES-1:0]              i_req,
    input  logic [ENTRIES-1:0][ENTRIES-1:0] i_age,
    output logic [ENTRIES-1:0]              o_grant
);

    // A requester wins unless some other requester is older than it. The
    // matrix is a strict total order over valid entries, so exactly one
    // requester survives whenever any request is present.
    always_comb begin
        o_grant = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            o_grant[i] = i_req[i];
            for (int j = 0; j < ENTRIES; j++) begin
                if (i_req[j] && i_age[j][i]) begin
                    o_grant[i] = 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/issue_queue_mp.sv
`default_nettype none
// ============================================================================
// Module      : issue_queue_mp
// Description : Out-of-order reservation station. Holds renamed micro-ops,
//               wakes their operands from NUM_CDB result buses and issues,
//               per functional unit, the oldest ready entry bound to that FU.
//               Supports a full flush and same-cycle CDB bypass on enqueue.
// Ports       : clk_i/reset_i     - clock, synchronous active-high reset
//               enq_*             - enqueue interface (enq_ready_o = free slot)
//               cdb_*             - result buses snooped for wakeup
//               fu_ready_i        - per-FU backpressure
//               flush_i           - squash all entries and in-flight issue
//               iss_*             - registered per-FU issue outputs
//               occupancy_o       - number of valid entries
// Revision    : 1.0 - initial release
// ============================================================================
module issue_queue_mp
    import issue_queue_mp_pkg::*;
#(
    parameter int ENTRIES   = 8,
    parameter int NUM_FU    = 4,
    parameter int NUM_CDB   = 4,
    parameter int WORD_W    = 16,
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 48
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  enq_v_i,
    output logic                                  enq_ready_o,
    input  logic [PREG_W-1:0]                     enq_dest_i,
    input  logic [1:0][PREG_W-1:0]                enq_src_id_i,
    input  logic [1:0]                            enq_src_v_i,
    input  logic [1:0][WORD_W-1:0]                enq_src_data_i,
    input  logic [iq_idx_w(NUM_FU)-1:0]           enq_fu_i,
    input  logic [PAYLOAD_W-1:0]                  enq_payload_i,
    input  logic [NUM_CDB-1:0]                    cdb_v_i,
    input  logic [NUM_CDB-1:0][PREG_W-1:0]        cdb_tag_i,
    input  logic [NUM_CDB-1:0][WORD_W-1:0]        cdb_data_i,
    input  logic [NUM_FU-1:0]                     fu_ready_i,
    input  logic                                  flush_i,
    output logic [NUM_FU-1:0]                     iss_v_o,
    output logic [NUM_FU-1:0][PREG_W-1:0]         iss_dest_o,
    output logic [NUM_FU-1:0][1:0][WORD_W-1:0]    iss_src_data_o,
    output logic [NUM_FU-1:0][PAYLOAD_W-1:0]      iss_payload_o,
    output logic [iq_cnt_w(ENTRIES)-1:0]          occupancy_o
);

    localparam int c_FU_W  = iq_idx_w(NUM_FU);
    localparam int c_IDX_W = iq_idx_w(ENTRIES);
    localparam int c_CNT_W = iq_cnt_w(ENTRIES);

    typedef struct packed {
        logic                     valid;
        logic [PREG_W-1:0]        dest;
        logic [1:0][PREG_W-1:0]   src_id;
        logic [1:0]               src_v;
        logic [1:0][WORD_W-1:0]   src_data;
        logic [c_FU_W-1:0]        fu;
        logic [PAYLOAD_W-1:0]     payload;
    } iq_entry_t;

    iq_entry_t                        r_entry     [ENTRIES];
    iq_entry_t                        w_entry_nxt [ENTRIES];
    logic [ENTRIES-1:0][ENTRIES-1:0]  r_age;
    logic [ENTRIES-1:0][ENTRIES-1:0]  w_age_nxt;
    logic [c_CNT_W-1:0]               r_occ;
    logic [c_CNT_W-1:0]               w_occ_nxt;
    logic [c_CNT_W-1:0]               w_iss_cnt;

    logic [ENTRIES-1:0]               w_valid;
    logic [ENTRIES-1:0]               w_ready;
    logic [ENTRIES-1:0]               w_issued;
    logic [ENTRIES-1:0]               w_grant [NUM_FU];
    logic                             w_free_found;
    logic [c_IDX_W-1:0]               w_free_idx;
    logic                             w_enq_fire;
    logic [WORD_W:0]                  w_snp;

    logic [NUM_FU-1:0]                    r_iss_v,       w_iss_v;
    logic [NUM_FU-1:0][PREG_W-1:0]        r_iss_dest,    w_iss_dest;
    logic [NUM_FU-1:0][1:0][WORD_W-1:0]   r_iss_data,    w_iss_data;
    logic [NUM_FU-1:0][PAYLOAD_W-1:0]     r_iss_payload, w_iss_payload;

    // Returns {hit, data} for a tag against all CDBs. Scanning from the top
    // down lets the lowest-index matching bus overwrite any higher one.
    function automatic logic [WORD_W:0] f_snoop(input logic [PREG_W-1:0] tag);
        logic [WORD_W:0] res;
        res = '0;
        for (int b = NUM_CDB - 1; b >= 0; b--) begin
            if (cdb_v_i[b] && (cdb_tag_i[b] == tag)) begin
                res = {1'b1, cdb_data_i[b]};
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Entry status and free-slot pick (lowest-index free entry)
    // ------------------------------------------------------------------
    always_comb begin
        w_valid = '0;
        w_ready = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            w_valid[e] = r_entry[e].valid;
            w_ready[e] = r_entry[e].valid & (&r_entry[e].src_v);
        end
    end

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (!w_valid[e]) begin
                w_free_found = 1'b1;
                w_free_idx   = c_IDX_W'(e);
            end
        end
    end

    // Ready depends on stored state only; a slot freed by this cycle's issue
    // is not offered to the enqueue side until the following cycle.
    assign enq_ready_o = ~reset_i & w_free_found;
    assign w_enq_fire  = enq_v_i & enq_ready_o & ~flush_i;

    // ------------------------------------------------------------------
    // Per-FU oldest-ready select
    // ------------------------------------------------------------------
    for (genvar f = 0; f < NUM_FU; f++) begin : g_fu_sel
        localparam logic [c_FU_W-1:0] c_FU_ID = c_FU_W'(f);
        logic [ENTRIES-1:0] w_req;

        always_comb begin
            w_req = '0;
            for (int e = 0; e < ENTRIES; e++) begin
                w_req[e] = w_ready[e] & (r_entry[e].fu == c_FU_ID) & fu_ready_i[f];
            end
        end

        iq_age_select #(
            .ENTRIES (ENTRIES)
        ) u_age_select (
            .i_req   (w_req),
            .i_age   (r_age),
            .o_grant (w_grant[f])
        );
    end

    // Issue mux: grants are one-hot per FU, so at most one entry drives each port.
    always_comb begin
        w_issued      = '0;
        w_iss_v       = '0;
        w_iss_dest    = '0;
        w_iss_data    = '0;
        w_iss_payload = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            w_iss_v[f] = |w_grant[f];
            w_issued   = w_issued | w_grant[f];
            for (int e = 0; e < ENTRIES; e++) begin
                if (w_grant[f][e]) begin
                    w_iss_dest[f]    = r_entry[e].dest;
                    w_iss_data[f]    = r_entry[e].src_data;
                    w_iss_payload[f] = r_entry[e].payload;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state: wakeup, free on issue, enqueue, then flush override
    // ------------------------------------------------------------------
    always_comb begin
        w_entry_nxt = r_entry;
        w_age_nxt   = r_age;
        w_snp       = '0;

        for (int e = 0; e < ENTRIES; e++) begin
            for (int s = 0; s < 2; s++) begin
                if (r_entry[e].valid && !r_entry[e].src_v[s]) begin
                    w_snp = f_snoop(r_entry[e].src_id[s]);
                    if (w_snp[WORD_W]) begin
                        w_entry_nxt[e].src_v[s]    = 1'b1;
                        w_entry_nxt[e].src_data[s] = w_snp[WORD_W-1:0];
                    end
                end
            end
        end

        // Freed entries drop out of the age order in both directions.
        for (int e = 0; e < ENTRIES; e++) begin
            if (w_issued[e]) begin
                w_entry_nxt[e].valid = 1'b0;
                w_age_nxt[e]         = '0;
                for (int j = 0; j < ENTRIES; j++) begin
                    w_age_nxt[j][e] = 1'b0;
                end
            end
        end

        if (w_enq_fire) begin
            w_entry_nxt[w_free_idx].valid    = 1'b1;
            w_entry_nxt[w_free_idx].dest     = enq_dest_i;
            w_entry_nxt[w_free_idx].src_id   = enq_src_id_i;
            w_entry_nxt[w_free_idx].src_v    = enq_src_v_i;
            w_entry_nxt[w_free_idx].src_data = enq_src_data_i;
            w_entry_nxt[w_free_idx].fu       = enq_fu_i;
            w_entry_nxt[w_free_idx].payload  = enq_payload_i;
            for (int s = 0; s < 2; s++) begin
                if (!enq_src_v_i[s]) begin
                    w_snp = f_snoop(enq_src_id_i[s]);
                    if (w_snp[WORD_W]) begin
                        w_entry_nxt[w_free_idx].src_v[s]    = 1'b1;
                        w_entry_nxt[w_free_idx].src_data[s] = w_snp[WORD_W-1:0];
                    end
                end
            end
            // Newcomer is younger than every entry that survives this cycle.
            w_age_nxt[w_free_idx] = '0;
            for (int j = 0; j < ENTRIES; j++) begin
                w_age_nxt[j][w_free_idx] = w_valid[j] & ~w_issued[j];
            end
        end

        if (flush_i) begin
            for (int e = 0; e < ENTRIES; e++) begin
                w_entry_nxt[e] = '0;
            end
            w_age_nxt = '0;
        end
    end

    always_comb begin
        w_iss_cnt = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            w_iss_cnt = w_iss_cnt + c_CNT_W'(w_issued[e]);
        end
        w_occ_nxt = flush_i ? '0 : (r_occ + c_CNT_W'(w_enq_fire) - w_iss_cnt);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int e = 0; e < ENTRIES; e++) begin
                r_entry[e] <= '0;
            end
            r_age         <= '0;
            r_occ         <= '0;
            r_iss_v       <= '0;
            r_iss_dest    <= '0;
            r_iss_data    <= '0;
            r_iss_payload <= '0;
        end else begin
            r_entry <= w_entry_nxt;
            r_age   <= w_age_nxt;
            r_occ   <= w_occ_nxt;
            if (flush_i) begin
                r_iss_v       <= '0;
                r_iss_dest    <= '0;
                r_iss_data    <= '0;
                r_iss_payload <= '0;
            end else begin
                r_iss_v       <= w_iss_v;
                r_iss_dest    <= w_iss_dest;
                r_iss_data    <= w_iss_data;
                r_iss_payload <= w_iss_payload;
            end
        end
    end

    assign iss_v_o        = r_iss_v;
    assign iss_dest_o     = r_iss_dest;
    assign iss_src_data_o = r_iss_data;
    assign iss_payload_o  = r_iss_payload;
    assign occupancy_o    = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_issue_queue_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_queue_mp
// Description : Self-checking bench for issue_queue_mp (default parameters).
//               A table of per-cycle vectors covers single issue, age order,
//               parallel issue with backpressure and enqueue bypass; hand
//               sequences cover full queue, age-vs-index order and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_queue_mp;

    logic                     clk_i = 1'b0;
    logic                     reset_i;
    logic                     enq_v_i;
    logic                     enq_ready_o;
    logic [5:0]               enq_dest_i;
    logic [1:0][5:0]          enq_src_id_i;
    logic [1:0]               enq_src_v_i;
    logic [1:0][15:0]         enq_src_data_i;
    logic [1:0]               enq_fu_i;
    logic [47:0]              enq_payload_i;
    logic [3:0]               cdb_v_i;
    logic [3:0][5:0]          cdb_tag_i;
    logic [3:0][15:0]         cdb_data_i;
    logic [3:0]               fu_ready_i;
    logic                     flush_i;
    logic [3:0]               iss_v_o;
    logic [3:0][5:0]          iss_dest_o;
    logic [3:0][1:0][15:0]    iss_src_data_o;
    logic [3:0][47:0]         iss_payload_o;
    logic [3:0]               occupancy_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    issue_queue_mp u_dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .enq_v_i        (enq_v_i),
        .enq_ready_o    (enq_ready_o),
        .enq_dest_i     (enq_dest_i),
        .enq_src_id_i   (enq_src_id_i),
        .enq_src_v_i    (enq_src_v_i),
        .enq_src_data_i (enq_src_data_i),
        .enq_fu_i       (enq_fu_i),
        .enq_payload_i  (enq_payload_i),
        .cdb_v_i        (cdb_v_i),
        .cdb_tag_i      (cdb_tag_i),
        .cdb_data_i     (cdb_data_i),
        .fu_ready_i     (fu_ready_i),
        .flush_i        (flush_i),
        .iss_v_o        (iss_v_o),
        .iss_dest_o     (iss_dest_o),
        .iss_src_data_o (iss_src_data_o),
        .iss_payload_o  (iss_payload_o),
        .occupancy_o    (occupancy_o)
    );

    typedef struct {
        logic        enq_v;
        logic [5:0]  dest;
        logic [5:0]  id0;
        logic [5:0]  id1;
        logic [1:0]  sv;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  fu;
        logic        cv;
        logic [1:0]  cbus;
        logic [5:0]  ctag;
        logic [15:0] cdata;
        logic [3:0]  frdy;
        logic        flush;
        logic [3:0]  e_iss_v;
        logic [3:0]  e_occ;
        logic        e_rdy;
        int          e_fu;
        logic [5:0]  e_dest;
        logic [15:0] e_d0;
        logic [15:0] e_d1;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [47:0] pl(input logic [5:0] dest);
        return {16'hC0DE, 26'h0, dest};
    endfunction

    function automatic vec_t mk(
        input logic enq_v, input logic [5:0] dest, input logic [5:0] id0, input logic [5:0] id1,
        input logic [1:0] sv, input logic [15:0] d0, input logic [15:0] d1, input logic [1:0] fu,
        input logic cv, input logic [1:0] cbus, input logic [5:0] ctag, input logic [15:0] cdata,
        input logic [3:0] frdy, input logic flush,
        input logic [3:0] e_iss_v, input logic [3:0] e_occ, input logic e_rdy,
        input int e_fu, input logic [5:0] e_dest, input logic [15:0] e_d0, input logic [15:0] e_d1);
        vec_t v;
        v.enq_v = enq_v; v.dest = dest; v.id0 = id0; v.id1 = id1; v.sv = sv;
        v.d0 = d0; v.d1 = d1; v.fu = fu; v.cv = cv; v.cbus = cbus; v.ctag = ctag;
        v.cdata = cdata; v.frdy = frdy; v.flush = flush; v.e_iss_v = e_iss_v;
        v.e_occ = e_occ; v.e_rdy = e_rdy; v.e_fu = e_fu; v.e_dest = e_dest;
        v.e_d0 = e_d0; v.e_d1 = e_d1;
        return v;
    endfunction

    function automatic vec_t idl(input logic [3:0] frdy, input logic [3:0] e_iss_v,
                                 input logic [3:0] e_occ, input int e_fu, input logic [5:0] e_dest,
                                 input logic [15:0] e_d0, input logic [15:0] e_d1);
        return mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, frdy, 0,
                  e_iss_v, e_occ, 1'b1, e_fu, e_dest, e_d0, e_d1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] e_iss_v, input logic [3:0] e_occ,
                              input logic e_rdy, input int e_fu, input logic [5:0] e_dest,
                              input logic [15:0] e_d0, input logic [15:0] e_d1);
        logic [3:0] nz;
        check({tag, " iss_v"}, 64'(iss_v_o), 64'(e_iss_v));
        check({tag, " occ"}, 64'(occupancy_o), 64'(e_occ));
        check({tag, " enq_ready"}, 64'(enq_ready_o), 64'(e_rdy));
        if (e_fu >= 0) begin
            check({tag, " dest"}, 64'(iss_dest_o[e_fu]), 64'(e_dest));
            check({tag, " src0"}, 64'(iss_src_data_o[e_fu][0]), 64'(e_d0));
            check({tag, " src1"}, 64'(iss_src_data_o[e_fu][1]), 64'(e_d1));
            check({tag, " payload"}, 64'(iss_payload_o[e_fu]), 64'(pl(e_dest)));
        end
        nz = '0;
        for (int f = 0; f < 4; f++) begin
            nz[f] = (|iss_dest_o[f]) | (|iss_src_data_o[f]) | (|iss_payload_o[f]);
        end
        check({tag, " idle_zero"}, 64'(nz & ~e_iss_v), 64'h0);
    endtask

    task automatic drive_enq(input logic v, input logic [5:0] dest, input logic [5:0] id0,
                             input logic [1:0] sv, input logic [15:0] d0, input logic [15:0] d1,
                             input logic [1:0] fu);
        enq_v_i           = v;
        enq_dest_i        = dest;
        enq_src_id_i[0]   = id0;
        enq_src_id_i[1]   = 6'd0;
        enq_src_v_i       = sv;
        enq_src_data_i[0] = d0;
        enq_src_data_i[1] = d1;
        enq_fu_i          = fu;
        enq_payload_i     = pl(dest);
    endtask

    task automatic clr_cdb();
        cdb_v_i    = '0;
        cdb_tag_i  = '0;
        cdb_data_i = '0;
    endtask

    task automatic drive_cdb(input int bus, input logic [5:0] tag, input logic [15:0] data);
        cdb_v_i[bus]    = 1'b1;
        cdb_tag_i[bus]  = tag;
        cdb_data_i[bus] = data;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply(input int idx, input vec_t v);
        enq_v_i           = v.enq_v;
        enq_dest_i        = v.dest;
        enq_src_id_i[0]   = v.id0;
        enq_src_id_i[1]   = v.id1;
        enq_src_v_i       = v.sv;
        enq_src_data_i[0] = v.d0;
        enq_src_data_i[1] = v.d1;
        enq_fu_i          = v.fu;
        enq_payload_i     = pl(v.dest);
        clr_cdb();
        if (v.cv) drive_cdb(int'(v.cbus), v.ctag, v.cdata);
        fu_ready_i = v.frdy;
        flush_i    = v.flush;
        step();
        expect_out($sformatf("vec%0d", idx), v.e_iss_v, v.e_occ, v.e_rdy,
                   v.e_fu, v.e_dest, v.e_d0, v.e_d1);
    endtask

    initial begin
        // Basic: single op on FU1, issue two cycles after enqueue.
        vecs.push_back(mk(1, 6'd10, 0, 0, 2'b11, 16'h1111, 16'h2222, 2'd1, 0, 0, 0, 0, 4'hF, 0, 4'h0, 4'd1, 1, -1, 0, 0, 0));
        vecs.push_back(idl(4'hF, 4'b0010, 4'd0, 1, 6'd10, 16'h1111, 16'h2222));
        vecs.push_back(idl(4'hF, 4'b0000, 4'd0, -1, 0, 0, 0));
        // Age order: B then C on FU0, both woken by tag 5 together.
        vecs.push_back(mk(1, 6'd20, 6'd5, 0, 2'b10, 0, 16'h0B01, 2'd0, 0, 0, 0, 0, 4'hF, 0, 4'h0, 4'd1, 1, -1, 0, 0, 0));
        vecs.push_back(mk(1, 6'd21, 6'd5, 0, 2'b10, 0, 16'h0C01, 2'd0, 0, 0, 0, 0, 4'hF, 0, 4'h0, 4'd2, 1, -1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 2'd0, 1, 2'd1, 6'd5, 16'h5555, 4'hF, 0, 4'h0, 4'd2, 1, -1, 0, 0, 0));
        vecs.push_back(idl(4'hF, 4'b0001, 4'd1, 0, 6'd20, 16'h5555, 16'h0B01));
        vecs.push_back(idl(4'hF, 4'b0001, 4'd0, 0, 6'd21, 16'h5555, 16'h0C01));
        vecs.push_back(idl(4'hF, 4'b0000, 4'd0, -1, 0, 0, 0));
        // Parallel issue with FU2 backpressured, then released.
        for (int f = 0; f < 4; f++) begin
            vecs.push_back(mk(1, 6'(30 + f), 0, 0, 2'b11, 16'h1030 + 16'(f), 16'h2030 + 16'(f), 2'(f),
                              0, 0, 0, 0, 4'h0, 0, 4'h0, 4'(f + 1), 1, -1, 0, 0, 0));
        end
        vecs.push_back(idl(4'hB, 4'b1011, 4'd1, 3, 6'd33, 16'h1033, 16'h2033));
        vecs.push_back(idl(4'h0, 4'b0000, 4'd1, -1, 0, 0, 0));
        vecs.push_back(idl(4'hF, 4'b0100, 4'd0, 2, 6'd32, 16'h1032, 16'h2032));
        // All four FUs in the same cycle.
        for (int f = 0; f < 4; f++) begin
            vecs.push_back(mk(1, 6'(40 + f), 0, 0, 2'b11, 16'h1040 + 16'(f), 16'h2040 + 16'(f), 2'(f),
                              0, 0, 0, 0, 4'h0, 0, 4'h0, 4'(f + 1), 1, -1, 0, 0, 0));
        end
        vecs.push_back(idl(4'hF, 4'hF, 4'd0, 2, 6'd42, 16'h1042, 16'h2042));
        // Enqueue bypass: tag 9 on CDB2 in the enqueue cycle.
        vecs.push_back(mk(1, 6'd50, 6'd9, 6'd3, 2'b10, 0, 16'h3333, 2'd3, 1, 2'd2, 6'd9, 16'hBEEF, 4'hF, 0, 4'h0, 4'd1, 1, -1, 0, 0, 0));
        vecs.push_back(idl(4'hF, 4'b1000, 4'd0, 3, 6'd50, 16'hBEEF, 16'h3333));
        // Non-matching tag must not wake; matching tag later does.
        vecs.push_back(mk(1, 6'd51, 6'd9, 6'd3, 2'b10, 0, 16'h3434, 2'd3, 1, 2'd0, 6'd8, 16'hDEAD, 4'hF, 0, 4'h0, 4'd1, 1, -1, 0, 0, 0));
        vecs.push_back(idl(4'hF, 4'b0000, 4'd1, -1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 2'd0, 1, 2'd0, 6'd9, 16'h9191, 4'hF, 0, 4'h0, 4'd1, 1, -1, 0, 0, 0));
        vecs.push_back(idl(4'hF, 4'b1000, 4'd0, 3, 6'd51, 16'h9191, 16'h3434));

        // ---------------- reset ----------------
        reset_i    = 1'b1;
        flush_i    = 1'b0;
        fu_ready_i = 4'hF;
        drive_enq(0, 0, 0, 2'b00, 0, 0, 0);
        clr_cdb();
        step();
        step();
        expect_out("reset", 4'h0, 4'd0, 1'b0, -1, 0, 0, 0);
        reset_i = 1'b0;
        #1;
        check("post_reset enq_ready", 64'(enq_ready_o), 64'h1);

        // ---------------- table ----------------
        foreach (vecs[i]) apply(i, vecs[i]);

        // ---------------- full / backpressure ----------------
        clr_cdb();
        fu_ready_i = 4'hF;
        flush_i    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_enq(1, 6'(60 + i), 6'(20 + i), 2'b10, 0, 16'h6000 + 16'(i), 2'd0);
            step();
        end
        expect_out("full", 4'h0, 4'd8, 1'b0, -1, 0, 0, 0);
        drive_enq(1, 6'd7, 0, 2'b11, 16'h0707, 16'h0707, 2'd1);
        step();
        expect_out("full_ignore", 4'h0, 4'd8, 1'b0, -1, 0, 0, 0);
        drive_cdb(0, 6'd23, 16'h7777);
        drive_cdb(2, 6'd23, 16'h8888);
        step();
        expect_out("full_wake", 4'h0, 4'd8, 1'b0, -1, 0, 0, 0);
        clr_cdb();
        step();
        expect_out("full_issue", 4'b0001, 4'd7, 1'b1, 0, 6'd63, 16'h7777, 16'h6003);

        // Younger entry in a lower slot must lose to an older higher slot.
        drive_enq(1, 6'd68, 6'd30, 2'b10, 0, 16'h6008, 2'd0);
        step();
        expect_out("refill", 4'h0, 4'd8, 1'b0, -1, 0, 0, 0);
        drive_enq(0, 0, 0, 2'b00, 0, 0, 0);
        drive_cdb(0, 6'd30, 16'h3030);
        drive_cdb(1, 6'd27, 16'h2727);
        step();
        expect_out("age_wake", 4'h0, 4'd8, 1'b0, -1, 0, 0, 0);
        clr_cdb();
        step();
        expect_out("age_old", 4'b0001, 4'd7, 1'b1, 0, 6'd67, 16'h2727, 16'h6007);
        step();
        expect_out("age_young", 4'b0001, 4'd6, 1'b1, 0, 6'd68, 16'h3030, 16'h6008);

        // ---------------- flush ----------------
        drive_cdb(0, 6'd20, 16'hAAAA);
        step();
        expect_out("pre_flush", 4'h0, 4'd6, 1'b1, -1, 0, 0, 0);
        clr_cdb();
        flush_i = 1'b1;
        drive_enq(1, 6'd7, 0, 2'b11, 16'h0707, 16'h0707, 2'd1);
        step();
        expect_out("flush", 4'h0, 4'd0, 1'b1, -1, 0, 0, 0);
        flush_i = 1'b0;
        drive_enq(0, 0, 0, 2'b00, 0, 0, 0);
        drive_cdb(0, 6'd21, 16'h2121);
        step();
        expect_out("post_flush", 4'h0, 4'd0, 1'b1, -1, 0, 0, 0);
        clr_cdb();
        drive_enq(1, 6'd70, 0, 2'b11, 16'h7070, 16'h0707, 2'd2);
        step();
        expect_out("reuse_enq", 4'h0, 4'd1, 1'b1, -1, 0, 0, 0);
        drive_enq(0, 0, 0, 2'b00, 0, 0, 0);
        step();
        expect_out("reuse_iss", 4'b0100, 4'd0, 1'b1, 2, 6'd70, 16'h7070, 16'h0707);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
